circuit_capture: RTL and testbench

CIRCUIT_CAPTURE -- requirements
Module: circuit_capture

---
 rtl/circuit_capture_pkg.sv | 14 +
 rtl/circuit_capture_mem.sv | 25 ++
 rtl/circuit_capture.sv | 99 +++++++++
 tb/tb_circuit_capture.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/circuit_capture_pkg.sv
// Shared defaults for the circuit capture FIFO: data width, depth, pointer sizing
// and the width of the dropped-sample counter.
package circuit_capture_pkg;

    localparam int CC_W_DEFAULT     = 32;
    localparam int CC_DEPTH_DEFAULT = 8;
    localparam int CC_DROP_W        = 16;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int cc_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/circuit_capture_mem.sv
// Storage for the capture FIFO: DEPTH x W register array with one synchronous
// write port and one combinational read port. Contents are deliberately not reset.
module circuit_capture_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/circuit_capture.sv
// First-word-fall-through capture FIFO behind an upstream circuit stage, with a
// sticky overflow flag and a saturating count of samples dropped while full.
module circuit_capture
    import circuit_capture_pkg::*;
#(
    parameter int W     = CC_W_DEFAULT,
    parameter int DEPTH = CC_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [W-1:0]           y,
    output logic [W-1:0]           m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [CC_DROP_W-1:0]   drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = cc_ptr_w(DEPTH);
    localparam logic [CC_DROP_W-1:0] DROP_MAX = '1;

    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic                 overflow_reg;
    logic [CC_DROP_W-1:0] drop_cnt_reg;

    logic         full;
    logic         empty;
    logic         pop;
    logic         push;
    logic         drop;
    logic [W-1:0] rd_data;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop in the same cycle frees the head slot, so a push at full still lands.
    assign pop  = !empty && m_ready;
    assign push = en && (!full || pop);
    assign drop = en && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // A drop coinciding with clr_ovf wins: the flag stays set and the count restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (drop) begin
                overflow_reg <= 1'b1;
                if (clr_ovf) begin
                    drop_cnt_reg <= CC_DROP_W'(1);
                end else if (drop_cnt_reg != DROP_MAX) begin
                    drop_cnt_reg <= drop_cnt_reg + 1'b1;
                end
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
                drop_cnt_reg <= '0;
            end
        end
    end

    circuit_capture_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (y),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (rd_data)
    );

    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign m_valid  = !empty;
    assign m_data   = m_valid ? rd_data : '0;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_circuit_capture.sv
// Directed bench for circuit_capture: reset, latency, overflow/drop, full push+pop,
// streaming, overflow clear and asynchronous mid-operation reset.
module tb_circuit_capture;

    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [W-1:0]           y;
    logic [W-1:0]           m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic                   clr_ovf;
    logic [15:0]            drop_cnt;

    int errors = 0;
    int checks = 0;

    circuit_capture #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .y        (y),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Apply current inputs across one rising edge, then sample 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        logic [W-1:0] sval;
        rst = 1'b0; en = 1'b0; y = '0; m_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) cycle();

        check("rst_valid", 32'(m_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_data", m_data, 0);

        // First push lands on the first edge after release.
        rst = 1'b1;
        en = 1'b1; y = 5;
        cycle();
        idle();
        check("lat_valid", 32'(m_valid), 1);
        check("lat_data", m_data, 5);
        check("lat_level", 32'(level), 1);
        m_ready = 1'b1;
        cycle();
        idle();
        check("pop_empty_valid", 32'(m_valid), 0);

        // Fill to full, then one more push is dropped.
        for (int i = 1; i <= 8; i++) begin
            en = 1'b1; y = 32'(i);
            cycle();
        end
        y = 9;
        cycle();
        idle();
        check("full_level", 32'(level), 8);
        check("full_ovf", 32'(overflow), 1);
        check("full_drop", 32'(drop_cnt), 1);
        check("full_head_stable", m_data, 1);
        cycle();
        check("stall_head_stable", m_data, 1);

        // Push and pop together at full: level holds and 42 joins the tail.
        en = 1'b1; y = 42; m_ready = 1'b1;
        cycle();
        idle();
        check("fullpp_level", 32'(level), 8);
        check("fullpp_drop", 32'(drop_cnt), 1);
        for (int i = 2; i <= 8; i++) begin
            check($sformatf("drain_%0d", i), m_data, 32'(i));
            m_ready = 1'b1;
            cycle();
        end
        check("drain_last", m_data, 42);
        cycle();
        check("drained_level", 32'(level), 0);
        check("drained_valid", 32'(m_valid), 0);
        cycle();
        idle();
        check("ready_on_empty", 32'(level), 0);

        // clr_ovf with a concurrent drop restarts the count at 1; alone it clears.
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; y = 32'(100 + i);
            cycle();
        end
        y = 200;
        cycle();
        cycle();
        check("drop_two", 32'(drop_cnt), 3);
        clr_ovf = 1'b1;
        cycle();
        check("clrdrop_ovf", 32'(overflow), 1);
        check("clrdrop_cnt", 32'(drop_cnt), 1);
        en = 1'b0;
        cycle();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 0);
        check("clr_cnt", 32'(drop_cnt), 0);
        check("clr_keep_level", 32'(level), 8);

        // Bring level to 5, then reset asynchronously between edges.
        m_ready = 1'b1;
        repeat (3) cycle();
        idle();
        check("pre_rst_level", 32'(level), 5);
        check("pre_rst_head", m_data, 103);
        #2 rst = 1'b0;
        #1;
        check("async_valid", 32'(m_valid), 0);
        check("async_level", 32'(level), 0);
        check("async_data", m_data, 0);
        cycle();
        rst = 1'b1;
        en = 1'b1; y = 5;
        cycle();
        idle();
        check("post_rst_valid", 32'(m_valid), 1);
        check("post_rst_data", m_data, 5);
        check("post_rst_level", 32'(level), 1);
        m_ready = 1'b1;
        cycle();
        idle();
        check("post_rst_empty", 32'(level), 0);

        // Streaming: each sample appears at the head one cycle later, level stays at 1.
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sval = 32'($urandom % 10);
            y = sval;
            cycle();
            check($sformatf("stream_data_%0d", i), m_data, sval);
            check($sformatf("stream_level_%0d", i), 32'(level), 1);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
